fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the register/memory stage.
- Keeps the program counter and reads 16-bit words from instruction memory over a req/ack interface.
- Fetches a trailing immediate word when the opcode needs one, then holds IR/ImR stable for the downstream stage until it is consumed.
- Supports PC redirect for branches, jumps and restore.

---
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, reads instruction and optional immediate
// words over a req/ack memory port, and holds the result until downstream takes it.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] IMM_OP_MASK = 16'h00F0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_ack,
  input  logic        pc_load,
  input  logic [15:0] pc_in,
  input  logic        take,
  output logic [15:0] IR,
  output logic [15:0] ImR,
  output logic [15:0] instr_pc,
  output logic        valid,
  output logic [15:0] pc
);

  localparam logic [1:0] FETCH_I   = 2'd0;
  localparam logic [1:0] FETCH_IMM = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;

  logic [1:0] state;
  logic       needs_imm;

  assign needs_imm = IMM_OP_MASK[mem_data[15:12]];
  assign mem_addr  = pc;
  assign mem_rd    = !reset && (state != HOLD);

  // NOTE: all state uses non-blocking assignments so every branch reads the
  // pre-edge pc/state values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      IR       <= 16'h0000;
      ImR      <= 16'h0000;
      instr_pc <= 16'h0000;
      valid    <= 1'b0;
      state    <= FETCH_I;
    end else if (pc_load) begin
      // A redirect drops any in-flight ack and flushes a held instruction.
      pc    <= pc_in;
      valid <= 1'b0;
      state <= FETCH_I;
    end else begin
      case (state)
        FETCH_I: begin
          if (mem_ack) begin
            IR       <= mem_data;
            instr_pc <= pc;
            pc       <= pc + 16'd1;
            if (needs_imm) begin
              state <= FETCH_IMM;
            end else begin
              ImR   <= 16'h0000;
              valid <= 1'b1;
              state <= HOLD;
            end
          end
        end
        FETCH_IMM: begin
          if (mem_ack) begin
            ImR   <= mem_data;
            pc    <= pc + 16'd1;
            valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (take) begin
            valid <= 1'b0;
            state <= FETCH_I;
          end
        end
        default: state <= FETCH_I;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random take/redirect/reset/wait-state
// traffic, checked against an instruction-level model of the program in memory.
module tb_fetch_unit;

  localparam logic [15:0] RPC  = 16'h0000;
  localparam logic [15:0] MASK = 16'h00F0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr, mem_data, pc_in = 16'h0000;
  logic        mem_rd, mem_ack, pc_load = 1'b0, take = 1'b0;
  logic [15:0] IR, ImR, instr_pc, pc;
  logic        valid;

  logic        reset_w = 1'b1;
  logic [15:0] mem_addr_w, mem_data_w, IR_w, ImR_w, instr_pc_w, pc_w;
  logic        mem_rd_w, mem_ack_w, valid_w;

  logic [15:0] mem [0:65535];
  int          fixed_wait = 0;
  bit          rand_wait = 1'b0;
  int          wcnt = 0, wait_need = 0;

  int          total = 0, bad = 0;
  logic [15:0] model_pc = RPC;
  int          n_instr = 0, stall = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] h_ir, h_imr, h_ipc, h_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .IMM_OP_MASK(MASK)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_ack(mem_ack), .pc_load(pc_load), .pc_in(pc_in),
    .take(take), .IR(IR), .ImR(ImR), .instr_pc(instr_pc), .valid(valid), .pc(pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFF), .IMM_OP_MASK(MASK)) u_wrap (
    .clk(clk), .reset(reset_w), .mem_addr(mem_addr_w), .mem_rd(mem_rd_w),
    .mem_data(mem_data_w), .mem_ack(mem_ack_w), .pc_load(1'b0), .pc_in(16'h0000),
    .take(1'b0), .IR(IR_w), .ImR(ImR_w), .instr_pc(instr_pc_w), .valid(valid_w), .pc(pc_w)
  );

  // Memory responder: acks after a fixed or per-request random number of wait cycles.
  assign mem_data   = mem[mem_addr];
  assign mem_ack    = mem_rd && (wcnt >= (rand_wait ? wait_need : fixed_wait));
  assign mem_data_w = mem[mem_addr_w];
  assign mem_ack_w  = mem_rd_w;

  always @(posedge clk) begin
    wcnt <= (mem_rd && !mem_ack && !pc_load && !reset) ? wcnt + 1 : 0;
    if (mem_ack || pc_load || reset) wait_need <= $urandom_range(0, 3);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit has_imm(input logic [15:0] w);
    return ((MASK >> w[15:12]) & 16'd1) != 16'd0;
  endfunction

  // Per-cycle checks of the main DUT against the program model.
  task automatic monitor(input bit r, input bit pl, input logic [15:0] pin);
    logic [15:0] w, imm, nxt;
    check("addr_is_pc", mem_addr, pc);
    check("rd_rule", 16'(mem_rd), 16'(!reset && !valid));
    if (r) begin
      check("rst_pc", pc, RPC);
      check("rst_valid", 16'(valid), 16'd0);
      check("rst_ir", IR, 16'h0000);
      check("rst_imr", ImR, 16'h0000);
      check("rst_ipc", instr_pc, 16'h0000);
      model_pc = RPC;
    end else if (pl) begin
      check("load_valid", 16'(valid), 16'd0);
      check("load_pc", pc, pin);
      model_pc = pin;
    end else if (valid && !prev_valid) begin
      w   = mem[model_pc];
      nxt = model_pc + 16'd1;
      imm = 16'h0000;
      if (has_imm(w)) begin
        imm = mem[nxt];
        nxt = nxt + 16'd1;
      end
      check("model_ir", IR, w);
      check("model_imr", ImR, imm);
      check("model_ipc", instr_pc, model_pc);
      check("model_pc", pc, nxt);
      model_pc = nxt;
      n_instr++;
    end else if (valid && prev_valid) begin
      check("hold_ir", IR, h_ir);
      check("hold_imr", ImR, h_imr);
      check("hold_ipc", instr_pc, h_ipc);
      check("hold_pc", pc, h_pc);
    end
    if (!valid && !r && !pl) stall++;
    else stall = 0;
    if (stall > 16) begin
      check("progress", 16'(stall), 16'd0);
      stall = 0;
    end
    prev_valid = valid;
    h_ir = IR; h_imr = ImR; h_ipc = instr_pc; h_pc = pc;
  endtask

  task automatic cycle();
    bit r, pl;
    logic [15:0] pin;
    r = reset; pl = pc_load; pin = pc_in;
    @(posedge clk);
    @(negedge clk);
    monitor(r, pl, pin);
  endtask

  task automatic do_reset();
    reset = 1'b1; pc_load = 1'b0;
    cycle();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!valid && n < budget) begin
      cycle();
      n++;
    end
    if (!valid) check(tag, 16'(valid), 16'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    @(negedge clk);

    // Two 1-word instructions back to back, zero-wait memory, take tied high.
    mem[0] = 16'h1234; mem[1] = 16'h2001;
    take = 1'b1;
    do_reset();
    cycle();
    check("t1_valid", 16'(valid), 16'd1);
    check("t1_ir", IR, 16'h1234);
    check("t1_imr", ImR, 16'h0000);
    check("t1_ipc", instr_pc, 16'h0000);
    cycle();
    check("t1_drop", 16'(valid), 16'd0);
    cycle();
    check("t1_ir2", IR, 16'h2001);
    check("t1_ipc2", instr_pc, 16'h0001);
    check("t1_pc", pc, 16'h0002);

    // Instruction with a trailing immediate.
    mem[0] = 16'h5ABC; mem[1] = 16'hBEEF;
    take = 1'b0;
    do_reset();
    cycle();
    check("t2_novalid", 16'(valid), 16'd0);
    check("t2_addr1", mem_addr, 16'h0001);
    check("t2_rd", 16'(mem_rd), 16'd1);
    cycle();
    check("t2_valid", 16'(valid), 16'd1);
    check("t2_ir", IR, 16'h5ABC);
    check("t2_imr", ImR, 16'hBEEF);
    check("t2_ipc", instr_pc, 16'h0000);
    check("t2_pc", pc, 16'h0002);

    // Long hold, then a single-cycle take.
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t3_valid", 16'(valid), 16'd1);
      check("t3_rd", 16'(mem_rd), 16'd0);
      check("t3_pc", pc, 16'h0002);
    end
    take = 1'b1;
    cycle();
    take = 1'b0;
    check("t3_taken", 16'(valid), 16'd0);
    check("t3_fetch_rd", 16'(mem_rd), 16'd1);
    check("t3_fetch_addr", mem_addr, 16'h0002);

    // Redirect during memory wait states.
    mem[0] = 16'h1234; mem[16'h0040] = 16'h3333;
    fixed_wait = 3;
    do_reset();
    cycle();
    check("t4_wait", 16'(valid), 16'd0);
    pc_load = 1'b1; pc_in = 16'h0040;
    cycle();
    pc_load = 1'b0;
    check("t4_nocap", IR, 16'h0000);
    check("t4_addr", mem_addr, 16'h0040);
    wait_valid("t4_timeout", 16);
    check("t4_ipc", instr_pc, 16'h0040);
    check("t4_ir", IR, 16'h3333);

    // Redirect coincident with the immediate ack, then redirect+take in HOLD.
    fixed_wait = 0;
    mem[0] = 16'h5ABC; mem[1] = 16'hBEEF; mem[16'h0080] = 16'h1111; mem[16'h0090] = 16'h2222;
    do_reset();
    cycle();
    check("t5_in_imm", pc, 16'h0001);
    pc_load = 1'b1; pc_in = 16'h0080;
    cycle();
    pc_load = 1'b0;
    check("t5_imr_kept", ImR, 16'h0000);
    check("t5_valid", 16'(valid), 16'd0);
    check("t5_addr", mem_addr, 16'h0080);
    cycle();
    check("t5_ir", IR, 16'h1111);
    check("t5_ipc", instr_pc, 16'h0080);
    pc_load = 1'b1; pc_in = 16'h0090; take = 1'b1;
    cycle();
    pc_load = 1'b0; take = 1'b0;
    check("t5_flush", 16'(valid), 16'd0);
    check("t5_ir_old", IR, 16'h1111);
    check("t5_addr2", mem_addr, 16'h0090);
    cycle();
    check("t5_ir2", IR, 16'h2222);
    check("t5_ipc2", instr_pc, 16'h0090);

    // Wrap-around instance; main DUT parked in reset meanwhile.
    reset = 1'b1; reset_w = 1'b1;
    mem[16'hFFFF] = 16'h4000; mem[0] = 16'h0007;
    cycle();
    check("t6_rst_pc", pc_w, 16'hFFFF);
    reset_w = 1'b0;
    cycle();
    check("t6_pc_wrap", pc_w, 16'h0000);
    check("t6_novalid", 16'(valid_w), 16'd0);
    cycle();
    check("t6_valid", 16'(valid_w), 16'd1);
    check("t6_ir", IR_w, 16'h4000);
    check("t6_imr", ImR_w, 16'h0007);
    check("t6_ipc", instr_pc_w, 16'hFFFF);
    check("t6_pc", pc_w, 16'h0001);
    reset_w = 1'b1;
    cycle();
    reset_w = 1'b0;
    cycle();
    check("t6_mid_imm", pc_w, 16'h0000);
    reset_w = 1'b1;
    cycle();
    check("t6_rst2_pc", pc_w, 16'hFFFF);
    check("t6_rst2_valid", 16'(valid_w), 16'd0);
    reset = 1'b0;

    // Random traffic: wait states, takes, redirects (some near the wrap), resets.
    rand_wait = 1'b1;
    n0 = n_instr;
    for (int i = 0; i < 3000; i++) begin
      reset   = ($urandom_range(0, 199) == 0);
      pc_load = ($urandom_range(0, 39) == 0);
      pc_in   = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 2))
                                            : 16'($urandom);
      take    = ($urandom_range(0, 9) < 7);
      cycle();
    end
    reset = 1'b0; pc_load = 1'b0; take = 1'b0;
    check("rand_progress", 16'(n_instr - n0 > 100), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
